// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer:
// FSM state enum, LFSR seed/taps, default level periods and score ceiling.
package mole_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_UP,
        ST_GAP,
        ST_OVER
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int unsigned DEF_LEV1_PERIOD = 300000000;
    localparam int unsigned DEF_LEV2_PERIOD = 200000000;
    localparam int unsigned DEF_LEV3_PERIOD = 100000000;

    localparam int unsigned SCORE_MAX = 255;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, synchronously reset to the seed;
// exposes only the low OUT_W bits the caller needs.
module mole_lfsr
    import mole_pkg::*;
#(
    parameter int unsigned OUT_W = 3
) (
    input  logic             clk_orig,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge clk_orig) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: mole placement, scoring, countdown and level select.
// Optional build macro MOLE_MISS_PENALTY_EN: wrong-hole hits in UP/GAP cost one point.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned NUM_HOLES   = 8,
    parameter int unsigned GAME_SECS   = 30,
    parameter int unsigned LEV1_PERIOD = DEF_LEV1_PERIOD,
    parameter int unsigned LEV2_PERIOD = DEF_LEV2_PERIOD,
    parameter int unsigned LEV3_PERIOD = DEF_LEV3_PERIOD
) (
    input  logic                 clk_orig,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 lev_req,
    input  logic                 tick_1hz,
    input  logic                 tick_lev,
    input  logic [NUM_HOLES-1:0] hit,
    output logic [28:0]          lev_period,
    output logic [1:0]           level,
    output logic [NUM_HOLES-1:0] mole_oh,
    output logic [7:0]           score,
    output logic [5:0]           time_left,
    output logic                 busy,
    output logic                 game_over
);

    localparam int unsigned HB = $clog2(NUM_HOLES);
    localparam logic [NUM_HOLES-1:0] MOLE_LSB = NUM_HOLES'(1);

    state_t                 state, state_d;
    logic [NUM_HOLES-1:0]   mole_d;
    logic [7:0]             score_d;
    logic [5:0]             time_d;
    logic [1:0]             level_d, level_inc;
    logic [28:0]            period_d;
    logic [HB-1:0]          prev_hole, prev_d;
    logic [HB-1:0]          hole_raw, hole_pick;
    logic                   hit_valid, miss;

    function automatic logic [28:0] period_of(input logic [1:0] lv);
        case (lv)
            2'd1:    return 29'(LEV2_PERIOD);
            2'd2:    return 29'(LEV3_PERIOD);
            default: return 29'(LEV1_PERIOD);
        endcase
    endfunction

    mole_lfsr #(
        .OUT_W (HB)
    ) u_lfsr (
        .clk_orig (clk_orig),
        .rst      (rst),
        .en       (1'b1),
        .rnd      (hole_raw)
    );

    // Power-of-two hole count, so the HB-bit increment wraps mod NUM_HOLES.
    assign hole_pick = (hole_raw == prev_hole) ? hole_raw + 1'b1 : hole_raw;
    assign level_inc = (level == 2'd2) ? 2'd0 : level + 2'd1;
    assign hit_valid = (state == ST_UP) && ((hit & mole_oh) != '0);

`ifdef MOLE_MISS_PENALTY_EN
    assign miss = ((state == ST_UP) || (state == ST_GAP)) && ((hit & ~mole_oh) != '0);
`else
    assign miss = 1'b0;
`endif

    assign busy      = (state == ST_SPAWN) || (state == ST_UP) || (state == ST_GAP);
    assign game_over = (state == ST_OVER);

    always_comb begin
        state_d  = state;
        mole_d   = mole_oh;
        score_d  = score;
        time_d   = time_left;
        level_d  = level;
        period_d = lev_period;
        prev_d   = prev_hole;

        case (state)
            ST_IDLE, ST_OVER: begin
                mole_d = '0;
                if (start) begin
                    state_d = ST_SPAWN;
                    time_d  = 6'(GAME_SECS);
                    score_d = '0;
                end else if (lev_req) begin
                    level_d  = level_inc;
                    period_d = period_of(level_inc);
                end
            end
            ST_SPAWN: begin
                mole_d  = MOLE_LSB << hole_pick;
                prev_d  = hole_pick;
                state_d = ST_UP;
            end
            ST_UP: begin
                if (hit_valid || tick_lev) begin
                    mole_d  = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                mole_d = '0;
                if (tick_lev) begin
                    state_d = ST_SPAWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mole_d  = '0;
            end
        endcase

        // A valid hit and a penalised miss in the same cycle cancel out.
        if (hit_valid && !miss) begin
            if (score != 8'(SCORE_MAX)) begin
                score_d = score + 8'd1;
            end
        end else if (miss && !hit_valid) begin
            if (score != '0) begin
                score_d = score - 8'd1;
            end
        end

        // Expiry overrides whatever transition was chosen above.
        if (busy && tick_1hz && (time_left != '0)) begin
            time_d = time_left - 6'd1;
            if (time_left == 6'd1) begin
                state_d = ST_OVER;
                mole_d  = '0;
            end
        end
    end

    always_ff @(posedge clk_orig) begin
        if (rst) begin
            state      <= ST_IDLE;
            mole_oh    <= '0;
            score      <= '0;
            time_left  <= '0;
            level      <= '0;
            lev_period <= 29'(LEV1_PERIOD);
            prev_hole  <= '0;
        end else begin
            state      <= state_d;
            mole_oh    <= mole_d;
            score      <= score_d;
            time_left  <= time_d;
            level      <= level_d;
            lev_period <= period_d;
            prev_hole  <= prev_d;
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized self-checking bench for mole_round_ctrl against a behavioural game model.
// Build with +define+MOLE_MISS_PENALTY_EN to check the miss-penalty variant.
module tb_mole_round_ctrl;

    localparam int unsigned NH = 8;
    localparam int unsigned GS = 4;

    logic          clk_orig = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          lev_req = 1'b0;
    logic          tick_1hz = 1'b0;
    logic          tick_lev = 1'b0;
    logic [NH-1:0] hit = '0;
    logic [28:0]   lev_period;
    logic [1:0]    level;
    logic [NH-1:0] mole_oh;
    logic [7:0]    score;
    logic [5:0]    time_left;
    logic          busy;
    logic          game_over;

    always #5 clk_orig = ~clk_orig;

    mole_round_ctrl #(
        .NUM_HOLES (NH),
        .GAME_SECS (GS)
    ) u_dut (
        .clk_orig   (clk_orig),
        .rst        (rst),
        .start      (start),
        .lev_req    (lev_req),
        .tick_1hz   (tick_1hz),
        .tick_lev   (tick_lev),
        .hit        (hit),
        .lev_period (lev_period),
        .level      (level),
        .mole_oh    (mole_oh),
        .score      (score),
        .time_left  (time_left),
        .busy       (busy),
        .game_over  (game_over)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Game model: a round is "active" while a mole is pending, raised or between moles.
    int unsigned periods [3] = '{300000000, 200000000, 100000000};
    bit          m_active, m_over, m_pending;
    int          m_mole, m_prev, m_score, m_time, m_level;
    int unsigned m_rng;

    function automatic int unsigned mole_vec(input int hole);
        return (hole < 0) ? 0 : (1 << hole);
    endfunction

    task automatic model_step();
        bit hit_ok, miss_hit;
        int h;
        if (rst) begin
            m_active = 0; m_over = 0; m_pending = 0;
            m_mole = -1; m_prev = 0; m_score = 0; m_time = 0; m_level = 0;
            m_rng = 16'hACE1;
            return;
        end
        if (!m_active) begin
            if (start) begin
                m_active = 1; m_over = 0; m_pending = 1; m_mole = -1;
                m_time = GS; m_score = 0;
            end else if (lev_req) begin
                m_level = (m_level + 1) % 3;
            end
        end else begin
            hit_ok   = (m_mole >= 0) && hit[m_mole];
            miss_hit = 0;
`ifdef MOLE_MISS_PENALTY_EN
            miss_hit = !m_pending && ((int'(hit) & ~mole_vec(m_mole) & 'hFF) != 0);
`endif
            m_score = m_score + (hit_ok ? 1 : 0) - (miss_hit ? 1 : 0);
            if (m_score > 255) m_score = 255;
            if (m_score < 0)   m_score = 0;
            if (m_pending) begin
                h = int'(m_rng % NH);
                if (h == m_prev) h = (h + 1) % NH;
                m_mole = h; m_prev = h; m_pending = 0;
            end else if (m_mole >= 0) begin
                if (hit_ok || tick_lev) m_mole = -1;
            end else if (tick_lev) begin
                m_pending = 1;
            end
            if (tick_1hz) begin
                m_time--;
                if (m_time == 0) begin
                    m_active = 0; m_over = 1; m_mole = -1; m_pending = 0;
                end
            end
        end
        m_rng = ((m_rng << 1) | (((m_rng >> 15) ^ (m_rng >> 13) ^ (m_rng >> 12) ^ (m_rng >> 10)) & 1)) & 'hFFFF;
    endtask

    task automatic compare_all();
        check("mole_oh",    32'(mole_oh),    mole_vec(m_mole));
        check("score",      32'(score),      32'(m_score));
        check("time_left",  32'(time_left),  32'(m_time));
        check("level",      32'(level),      32'(m_level));
        check("lev_period", 32'(lev_period), periods[m_level]);
        check("busy",       32'(busy),       32'(m_active));
        check("game_over",  32'(game_over),  32'(m_over));
    endtask

    task automatic step(input bit r, input bit s, input bit lr, input bit t1, input bit tl,
                        input logic [NH-1:0] h);
        rst = r; start = s; lev_req = lr; tick_1hz = t1; tick_lev = tl; hit = h;
        @(posedge clk_orig);
        model_step();
        #1;
        compare_all();
        rst = 0; start = 0; lev_req = 0; tick_1hz = 0; tick_lev = 0; hit = '0;
    endtask

    function automatic logic [NH-1:0] aim();
        return (m_mole >= 0) ? NH'(mole_vec(m_mole)) : '0;
    endfunction

    initial begin
        logic [NH-1:0] h;
        #1;
        repeat (3) step(1, 0, 0, 0, 0, '0);
        check("reset_period", 32'(lev_period), 32'd300000000);

        // Level cycling in IDLE, then start with a colliding lev_req.
        repeat (3) step(0, 0, 1, 0, 0, '0);
        step(0, 1, 1, 0, 0, '0);
        check("start_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(5, 0))
                0, 1:    h = aim();
                2:       h = NH'($urandom);
                3:       h = aim() | NH'(mole_vec(int'($urandom_range(NH - 1, 0))));
                default: h = '0;
            endcase
            step($urandom_range(599, 0) == 0, $urandom_range(29, 0) == 0,
                 $urandom_range(9, 0) == 0, $urandom_range(24, 0) == 0,
                 $urandom_range(3, 0) == 0, h);
        end

        // Drive the score to saturation with only correct hits.
        step(1, 0, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 2000 && !(m_score == 255 && i > 1200); i++) begin
            step(0, 0, 0, 0, (m_mole < 0) || ($urandom_range(7, 0) == 0), aim());
        end
        check("score_sat", 32'(score), 32'd255);

        // Expire the round, then confirm everything is frozen in OVER.
        for (int i = 0; i < GS; i++) begin
            step(0, 0, 0, 1, 0, aim());
            step(0, 0, 0, 0, 1, '0);
        end
        check("over_flag", 32'(game_over), 32'd1);
        check("over_mole", 32'(mole_oh), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, $urandom_range(1, 0), $urandom_range(1, 0), NH'($urandom));
        end
        step(0, 1, 0, 0, 0, '0);
        check("restart_time", 32'(time_left), 32'(GS));
        check("restart_score", 32'(score), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
